hyperbus_rwds_window_sampler: RTL and testbench



---
 rtl/hyperbus_rwds_window_sampler.sv | 166 ++++++++++++++++
 tb/tb_hyperbus_rwds_window_sampler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_rwds_window_sampler.sv
// hyperbus_rwds_window_sampler
// Per-channel RWDS capture for HyperBus PHYs. After chip-select falls, each
// channel counts PHY cycles and latches RWDS once, either at a single cycle
// index or as a 3-sample majority centred on that index. An optional training
// capture records the RWDS level for each of the first WinWidth cycles of a
// transfer. Everything runs in the PHY clock domain, and every output is
// driven directly by a flop.

module hyperbus_rwds_window_sampler #(
    parameter int unsigned NumPhys  = 2,
    parameter int unsigned CntWidth = 5,
    parameter int unsigned WinWidth = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [CntWidth-1:0]           cfg_idx_i,
    input  logic                          cfg_vote_i,
    input  logic                          cfg_train_i,
    input  logic [NumPhys-1:0]            cs_ni,
    input  logic [NumPhys-1:0]            rwds_i,
    output logic [NumPhys-1:0]            rwds_sample_o,
    output logic [NumPhys-1:0]            sample_valid_o,
    output logic [NumPhys-1:0]            abort_o,
    output logic [NumPhys*WinWidth-1:0]   train_vec_o,
    output logic [NumPhys-1:0]            train_valid_o
);

    // The counter saturates at CntMax. The sample point is clamped so that its
    // trigger count is always reachable: single mode needs eff, and vote mode
    // needs eff+1.
    localparam logic [CntWidth-1:0] CntZero  = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CntMax   = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] CntMaxM1 = CntMax - CntWidth'(1);
    localparam logic [CntWidth-1:0] CntMaxM2 = CntMax - CntWidth'(2);

    // Two-out-of-three majority used by the vote capture.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    for (genvar ch = 0; ch < NumPhys; ch++) begin : g_ch
        logic [CntWidth-1:0] cnt_r;
        logic [CntWidth-1:0] idx_r;
        logic                vote_r;
        logic                train_r;
        logic                armed_r;
        logic                cs_low_d_r;
        logic [1:0]          hist_r;
        logic                sample_r;
        logic                valid_r;
        logic                abort_r;
        logic [WinWidth-1:0] train_vec_r;
        logic                train_valid_r;

        logic [CntWidth-1:0] eff_s;
        logic [CntWidth-1:0] trig_cnt_s;
        logic                active_s;
        logic                trig_s;
        logic                abort_hit_s;
        logic                cap_val_s;
        logic                win_end_s;

        // Clamp the shadowed index to a legal sample point and derive the count
        // at which the capture fires.
        always_comb begin
            eff_s      = idx_r;
            trig_cnt_s = idx_r;
            if (vote_r) begin
                if (idx_r == CntZero) begin
                    eff_s = CntWidth'(1);
                end else if (idx_r > CntMaxM2) begin
                    eff_s = CntMaxM2;
                end else begin
                    eff_s = idx_r;
                end
                trig_cnt_s = eff_s + CntWidth'(1);
            end else begin
                if (idx_r > CntMaxM1) begin
                    eff_s = CntMaxM1;
                end else begin
                    eff_s = idx_r;
                end
                trig_cnt_s = eff_s;
            end
        end

        // Decode this cycle's capture, abort and window-end events.
        always_comb begin
            active_s    = ~cs_ni[ch];
            trig_s      = active_s & armed_r & (cnt_r == trig_cnt_s);
            abort_hit_s = cs_ni[ch] & armed_r & cs_low_d_r;
            if (vote_r) begin
                cap_val_s = majority3(hist_r[1], hist_r[0], rwds_i[ch]);
            end else begin
                cap_val_s = rwds_i[ch];
            end
            win_end_s   = active_s & train_r & (int'(cnt_r) == int'(WinWidth) - 1);
        end

        // Channel state: counter, config shadow, arming, history, and the
        // registered outputs.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_r         <= CntZero;
                idx_r         <= CntZero;
                vote_r        <= 1'b0;
                train_r       <= 1'b0;
                armed_r       <= 1'b1;
                cs_low_d_r    <= 1'b0;
                hist_r        <= 2'b00;
                sample_r      <= 1'b0;
                valid_r       <= 1'b0;
                abort_r       <= 1'b0;
                train_vec_r   <= {WinWidth{1'b0}};
                train_valid_r <= 1'b0;
            end else begin
                valid_r       <= 1'b0;
                abort_r       <= 1'b0;
                train_valid_r <= 1'b0;
                hist_r        <= {hist_r[0], rwds_i[ch]};
                cs_low_d_r    <= active_s;
                if (cs_ni[ch]) begin
                    // Idle: re-arm, clear the counter, and track the live config.
                    cnt_r   <= CntZero;
                    armed_r <= 1'b1;
                    idx_r   <= cfg_idx_i;
                    vote_r  <= cfg_vote_i;
                    train_r <= cfg_train_i;
                    if (abort_hit_s) begin
                        abort_r <= 1'b1;
                    end
                end else begin
                    if (cnt_r != CntMax) begin
                        cnt_r <= cnt_r + CntWidth'(1);
                    end
                    if (trig_s) begin
                        sample_r <= cap_val_s;
                        valid_r  <= 1'b1;
                        armed_r  <= 1'b0;
                    end
                    if (train_r) begin
                        // At count 0 the rest of the window is cleared, so a
                        // short transfer leaves only its own bits behind.
                        for (int k = 0; k < int'(WinWidth); k++) begin
                            if (int'(cnt_r) == k) begin
                                train_vec_r[k] <= rwds_i[ch];
                            end else if (cnt_r == CntZero) begin
                                train_vec_r[k] <= 1'b0;
                            end
                        end
                        if (win_end_s) begin
                            train_valid_r <= 1'b1;
                        end
                    end
                end
            end
        end

        assign rwds_sample_o[ch]                       = sample_r;
        assign sample_valid_o[ch]                      = valid_r;
        assign abort_o[ch]                             = abort_r;
        assign train_vec_o[ch*WinWidth +: WinWidth]    = train_vec_r;
        assign train_valid_o[ch]                       = train_valid_r;
    end

endmodule

// File: tb/tb_hyperbus_rwds_window_sampler.sv
// Directed bench for hyperbus_rwds_window_sampler using the default geometry
// (2 channels, 5-bit counter, 16-cycle window). Inputs change 1 ns after each
// rising edge, and outputs are sampled at that same point.

module tb_hyperbus_rwds_window_sampler;

    localparam int unsigned NumPhys  = 2;
    localparam int unsigned CntWidth = 5;
    localparam int unsigned WinWidth = 16;

    logic                        clk_i;
    logic                        rst_ni;
    logic [CntWidth-1:0]         cfg_idx_i;
    logic                        cfg_vote_i;
    logic                        cfg_train_i;
    logic [NumPhys-1:0]          cs_ni;
    logic [NumPhys-1:0]          rwds_i;
    logic [NumPhys-1:0]          rwds_sample_o;
    logic [NumPhys-1:0]          sample_valid_o;
    logic [NumPhys-1:0]          abort_o;
    logic [NumPhys*WinWidth-1:0] train_vec_o;
    logic [NumPhys-1:0]          train_valid_o;

    int checks_total  = 0;
    int checks_passed = 0;

    hyperbus_rwds_window_sampler #(
        .NumPhys  (NumPhys),
        .CntWidth (CntWidth),
        .WinWidth (WinWidth)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cfg_idx_i      (cfg_idx_i),
        .cfg_vote_i     (cfg_vote_i),
        .cfg_train_i    (cfg_train_i),
        .cs_ni          (cs_ni),
        .rwds_i         (rwds_i),
        .rwds_sample_o  (rwds_sample_o),
        .sample_valid_o (sample_valid_o),
        .abort_o        (abort_o),
        .train_vec_o    (train_vec_o),
        .train_valid_o  (train_valid_o)
    );

    // 100 MHz PHY clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One channel-0 transfer of len low cycles. pat[k] is RWDS at count k.
    // exp_* give the cycle (counted from the first low cycle) in which each
    // pulse must be seen; -1 means never.
    task automatic xfer0(input int len, input logic [31:0] pat, input int exp_v,
                         input int exp_a, input int exp_t, input int chg_cyc,
                         input logic [CntWidth-1:0] chg_idx);
        cs_ni[0]  = 1'b1;
        rwds_i[0] = 1'b0;
        tick;
        cs_ni[0]  = 1'b0;
        rwds_i[0] = pat[0];
        for (int cyc = 1; cyc <= len + 2; cyc++) begin
            tick;
            chk("sample_valid0", 32'(sample_valid_o[0]), 32'(cyc == exp_v));
            chk("abort0",        32'(abort_o[0]),        32'(cyc == exp_a));
            chk("train_valid0",  32'(train_valid_o[0]),  32'(cyc == exp_t));
            chk("ch1_quiet",     32'({sample_valid_o[1], abort_o[1], train_valid_o[1]}), 32'd0);
            if (cyc == chg_cyc) begin
                cfg_idx_i = chg_idx;
            end
            if (cyc < len) begin
                cs_ni[0]  = 1'b0;
                rwds_i[0] = pat[cyc[4:0]];
            end else begin
                cs_ni[0]  = 1'b1;
                rwds_i[0] = 1'b0;
            end
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        cfg_idx_i   = 5'd3;
        cfg_vote_i  = 1'b0;
        cfg_train_i = 1'b0;
        cs_ni       = 2'b11;
        rwds_i      = 2'b00;
        tick;
        tick;
        #3;
        rst_ni = 1'b1;
        tick;
        tick;

        // Reset state
        chk("rst_sample",      32'(rwds_sample_o),  32'd0);
        chk("rst_valid",       32'(sample_valid_o), 32'd0);
        chk("rst_abort",       32'(abort_o),        32'd0);
        chk("rst_train_vec",   32'(train_vec_o),    32'd0);
        chk("rst_train_valid", 32'(train_valid_o),  32'd0);

        // Single mode, idx=3, RWDS high only at count 3
        cfg_idx_i = 5'd3; cfg_vote_i = 1'b0; cfg_train_i = 1'b0;
        xfer0(10, 32'h0000_0008, 4, -1, -1, -1, 5'd0);
        chk("single_sample", 32'(rwds_sample_o[0]), 32'd1);

        // Vote mode, idx=4: counts 3,4,5 = 1,0,1 then 0,1,0
        cfg_idx_i = 5'd4; cfg_vote_i = 1'b1;
        xfer0(10, 32'h0000_0028, 6, -1, -1, -1, 5'd0);
        chk("vote_101", 32'(rwds_sample_o[0]), 32'd1);
        xfer0(10, 32'h0000_0010, 6, -1, -1, -1, 5'd0);
        chk("vote_010", 32'(rwds_sample_o[0]), 32'd0);

        // Abort: idx=8, 5 low cycles, idx changed to 2 during the transfer
        cfg_idx_i = 5'd8; cfg_vote_i = 1'b0;
        xfer0(5, 32'h0000_001F, -1, 6, -1, 1, 5'd2);
        chk("abort_hold", 32'(rwds_sample_o[0]), 32'd0);

        // Training: RWDS high at counts 2..5 of a 20-cycle transfer
        cfg_idx_i = 5'd8; cfg_train_i = 1'b1;
        xfer0(20, 32'h0000_003C, 9, -1, 16, -1, 5'd0);
        chk("train_vec_full", 32'(train_vec_o[15:0]),  32'h0000_003C);
        chk("train_vec_ch1",  32'(train_vec_o[31:16]), 32'd0);
        chk("train_sample",   32'(rwds_sample_o[0]),   32'd0);
        // A short transfer leaves a partial window and no train_valid
        xfer0(10, 32'h0000_0002, 9, -1, -1, -1, 5'd0);
        chk("train_vec_part", 32'(train_vec_o[15:0]), 32'h0000_0002);

        // Clamping: idx=31 single samples at count 30
        cfg_idx_i = 5'd31; cfg_vote_i = 1'b0; cfg_train_i = 1'b0;
        xfer0(32, 32'h4000_0000, 31, -1, -1, -1, 5'd0);
        chk("clamp_single", 32'(rwds_sample_o[0]), 32'd1);
        // Clamping: idx=0 vote uses counts 0..2
        cfg_idx_i = 5'd0; cfg_vote_i = 1'b1;
        xfer0(6, 32'hFFFF_FFF8, 3, -1, -1, -1, 5'd0);
        chk("clamp_vote", 32'(rwds_sample_o[0]), 32'd0);

        // Staggered channels: ch0 low cycles 0..7 and samples; ch1 low 2..4 and aborts
        cfg_idx_i = 5'd3; cfg_vote_i = 1'b0;
        cs_ni = 2'b11; rwds_i = 2'b00;
        tick;
        cs_ni = 2'b10; rwds_i = 2'b00;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick;
            chk("stag_valid", 32'(sample_valid_o), 32'({1'b0, cyc == 4}));
            chk("stag_abort", 32'(abort_o),        32'({cyc == 6, 1'b0}));
            cs_ni[0]  = (cyc < 8) ? 1'b0 : 1'b1;
            cs_ni[1]  = (cyc >= 2 && cyc <= 4) ? 1'b0 : 1'b1;
            rwds_i[0] = (cyc == 3) ? 1'b1 : 1'b0;
            rwds_i[1] = ~cs_ni[1];
        end
        chk("stag_sample", 32'(rwds_sample_o), 32'd1);

        // Reset asserted at count 2 of an armed training transfer
        cfg_idx_i = 5'd3; cfg_vote_i = 1'b0; cfg_train_i = 1'b1;
        cs_ni = 2'b11; rwds_i = 2'b00;
        tick;
        cs_ni[0] = 1'b0; rwds_i[0] = 1'b1;
        tick;
        tick;
        chk("pre_rst_vec", 32'(train_vec_o[15:0]), 32'h0000_0003);
        rst_ni = 1'b0;
        #2;
        chk("mid_rst_sample",      32'(rwds_sample_o),  32'd0);
        chk("mid_rst_valid",       32'(sample_valid_o), 32'd0);
        chk("mid_rst_abort",       32'(abort_o),        32'd0);
        chk("mid_rst_train_vec",   32'(train_vec_o),    32'd0);
        chk("mid_rst_train_valid", 32'(train_valid_o),  32'd0);
        #2;
        rst_ni = 1'b1;
        // Shadow config is now 0 (single, idx 0) and cs stays low: capture at count 0
        tick;
        chk("post_rst_valid",  32'(sample_valid_o), 32'd1);
        chk("post_rst_sample", 32'(rwds_sample_o),  32'd1);
        tick;
        chk("post_rst_once",   32'(sample_valid_o), 32'd0);
        chk("post_rst_notrain", 32'(train_vec_o),   32'd0);
        cs_ni = 2'b11; rwds_i = 2'b00;
        tick;
        tick;
        chk("end_no_abort", 32'(abort_o), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
